// File: rtl/spdif_burst_capture_if.sv
// spdif_burst_capture_if: MCB command and write-data port between the capture block and the memory controller
interface spdif_burst_capture_if;
  logic cmd_en;
  logic [2:0] cmd_instr;
  logic [5:0] cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic cmd_full;
  logic wr_en;
  logic [31:0] wr_data;
  logic [3:0] wr_mask;
  logic wr_full;
  logic [6:0] wr_count;
  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask,
    input cmd_full, wr_full, wr_count
  );
  modport slave (
    input cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask,
    output cmd_full, wr_full, wr_count
  );
endinterface

// File: rtl/spdif_burst_capture.sv
// spdif_burst_capture: B-aligned, channel-filtered S/PDIF subframe capture into MCB write bursts over a DRAM ring.
// Optional SPDIF_CAPTURE_PARITY_CHECK_EN drops and counts words whose E bit is set.
module spdif_burst_capture #(
  parameter int BURST_WORDS = 16,
  parameter logic [29:0] BASE_ADDR = 30'h0,
  parameter int RING_BYTES = 2**20
) (
  input logic clock,
  input logic reset,
  input logic sub_valid,
  input logic [31:0] sub_word,
  input logic start,
  input logic abort,
  input logic [31:0] frames,
  input logic [1:0] chan_mode,
  output logic [31:0] frames_remaining,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic [15:0] parity_errors,
  spdif_burst_capture_if.master mcb
);
  typedef enum logic [2:0] {IDLE, ARM, FILL, CMD, FLUSH} state_t;
  localparam logic [6:0] BW = 7'(BURST_WORDS);
  localparam logic [31:0] RING_MASK = 32'(RING_BYTES - 1);
  state_t state, state_nxt;
  logic [29:0] addr, addr_nxt;
  logic [6:0] fill, blen, flen, len, fill_nxt;
  logic abort_pend, chan_ok, par_ok, cand, accept, push, issue, fifo_full, load;
  logic [1:0] syn;
  assign syn = sub_word[3:2];
  assign load = (state == IDLE) && start;
  assign chan_ok = chan_mode == 2'b01 ? !syn[1] : chan_mode == 2'b10 ? syn == 2'b10 : 1'b1;
`ifdef SPDIF_CAPTURE_PARITY_CHECK_EN
  assign par_ok = !sub_word[0];
`else
  assign par_ok = 1'b1;
`endif
  // the B word that ends ARM is itself the first candidate
  assign cand = sub_valid && chan_ok && frames_remaining != '0 &&
                ((((state == FILL) || (state == ARM && syn == 2'b00)) && !abort) || (state == CMD));
  assign fifo_full = mcb.wr_full || (mcb.wr_count >= 7'd64);
  assign accept = cand && par_ok;
  assign push = accept && !fifo_full;
  assign flen = fill >= BW ? BW : fill;
  assign len = state == FLUSH ? flen : blen;
  assign issue = ((state == CMD) || (state == FLUSH && fill != '0)) && !mcb.cmd_full;
  assign fill_nxt = fill - (issue ? len : 7'd0) + {6'd0, push};
  assign addr_nxt = BASE_ADDR + 30'((32'(addr - BASE_ADDR) + 32'(len) * 32'd4) & RING_MASK);
  assign mcb.cmd_en = issue;
  assign mcb.cmd_instr = 3'b000;
  assign mcb.cmd_bl = issue ? 6'(len - 7'd1) : '0;
  assign mcb.cmd_byte_addr = issue ? addr : '0;
  assign mcb.wr_mask = '0;
  assign done = (state == IDLE) && (frames_remaining == '0);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start && frames != '0 ? ARM : IDLE;
      ARM: state_nxt = abort ? IDLE : sub_valid && syn == 2'b00 ? FILL : ARM;
      FILL: state_nxt = (fill >= BW) || ((abort || frames_remaining == '0) && fill != '0) ? CMD :
                        (abort || frames_remaining == '0) ? IDLE : FILL;
      // leftovers accepted while waiting on cmd_full still get their own burst
      CMD: state_nxt = !issue ? CMD : (abort_pend || abort) ? FLUSH :
                       (frames_remaining == '0 && fill_nxt == '0) ? IDLE : FILL;
      FLUSH: state_nxt = (fill == '0) || (issue && fill == flen) ? IDLE : FLUSH;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      frames_remaining <= '0;
      addr <= BASE_ADDR;
      fill <= '0;
      blen <= '0;
      abort_pend <= 1'b0;
      overflow <= 1'b0;
      mcb.wr_en <= 1'b0;
      mcb.wr_data <= '0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt != IDLE;
      mcb.wr_en <= push;
      if (push) mcb.wr_data <= sub_word;
      if (load) begin
        frames_remaining <= frames;
        addr <= BASE_ADDR;
        fill <= '0;
        overflow <= 1'b0;
        abort_pend <= 1'b0;
      end else begin
        if (push) frames_remaining <= frames_remaining - 32'd1;
        if (accept && fifo_full) overflow <= 1'b1;
        if (issue) addr <= addr_nxt;
        fill <= fill_nxt;
        if (state == FILL && state_nxt == CMD) blen <= flen;
        if ((state == FILL || state == CMD) && abort) abort_pend <= 1'b1;
      end
    end
`ifdef SPDIF_CAPTURE_PARITY_CHECK_EN
  logic [15:0] perr;
  always_ff @(posedge clock or posedge reset)
    if (reset) perr <= '0;
    else if (load) perr <= '0;
    else if (cand && !par_ok && perr != 16'hFFFF) perr <= perr + 16'd1;
  assign parity_errors = perr;
`else
  assign parity_errors = '0;
`endif
endmodule
